// File: rtl/tc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tc_seq_ctrl_if
// Description : Request/response bus between the tile sequencer and the AXI
//               master. The sequencer drives one burst request at a time and
//               the AXI master reports completion with rsp_finish.
// Revision    : 1.0 - initial release
// ============================================================================
interface tc_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [2:0]  req_sel;
    logic        req_issend;
    logic [31:0] req_bits;
    logic [4:0]  req_burst_num;
    logic [7:0]  req_burst_size;
    logic        rsp_finish;

    modport master (
        output req_valid, req_base, req_sel, req_issend, req_bits,
               req_burst_num, req_burst_size,
        input  req_ready, rsp_finish
    );

    modport slave (
        input  req_valid, req_base, req_sel, req_issend, req_bits,
               req_burst_num, req_burst_size,
        output req_ready, rsp_finish
    );
endinterface
`default_nettype wire

// File: rtl/tc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tc_seq_ctrl
// Description : Tensor-core tile sequencer. Loads C, A, B through burst
//               requests, times the systolic / accumulate / wait phases and
//               stores D, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_seq_ctrl #(
    parameter int MAX_BEATS  = 16,
    parameter int ACC_CYCLES = 2
) (
    input  wire           clk,
    input  wire           rst,
    input  wire           start,
    input  wire  [3:0]    cfg_type,
    input  wire  [127:0]  cfg_base,
    input  wire  [95:0]   cfg_time,
    tc_seq_ctrl_if.master bus,
    output logic          sa_start,
    output logic          sa_busy,
    output logic          acc_en,
    output logic [3:0]    state,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [3:0] c_IDLE       = 4'd0;
    localparam logic [3:0] c_READ_C     = 4'd1;
    localparam logic [3:0] c_LOAD_A     = 4'd2;
    localparam logic [3:0] c_LOAD_B     = 4'd3;
    localparam logic [3:0] c_SYSTOLIC   = 4'd4;
    localparam logic [3:0] c_ACCUMULATE = 4'd5;
    localparam logic [3:0] c_WAIT_WRITE = 4'd6;
    localparam logic [3:0] c_WRITE_BACK = 4'd7;
    localparam logic [3:0] c_FINISH     = 4'd8;

    localparam logic [31:0] c_REQ_BITS  = 32'(MAX_BEATS * 256);
    localparam logic [31:0] c_REQ_BYTES = 32'(MAX_BEATS * 32);
    localparam logic [31:0] c_CD_BITS   = 32'd8192;
    localparam logic [31:0] c_ACC_LOAD  = 32'(ACC_CYCLES);

    logic [3:0]   r_state;
    logic [3:0]   w_state_nxt;
    logic         r_entry;
    logic [3:0]   r_type;
    logic [127:0] r_base;
    logic [95:0]  r_time;
    logic [31:0]  r_cnt;
    logic [31:0]  r_idx;
    logic         r_valid;
    logic         r_outst;
    logic         r_all_fin;
    logic         r_cfg_err;

    logic [2:0]   w_shift;
    logic [31:0]  w_mat_bits;
    logic [31:0]  w_mat_base;
    logic [2:0]   w_sel;
    logic [31:0]  w_nreq;
    logic [31:0]  w_rem;
    logic [31:0]  w_bits;
    logic [31:0]  w_req_base;
    logic [31:0]  w_cnt_load;
    logic         w_xfer_state;
    logic         w_fin;
    logic         w_last;
    logic         w_tmr_done;
    logic         w_start_ok;
    logic         w_changing;

    // A is M*K and B is K*N elements; both collapse to power-of-two shifts.
    assign w_shift      = 3'(r_type[3:2]) + 3'(r_type[1:0]);
    assign w_nreq       = (w_mat_bits + c_REQ_BITS - 32'd1) / c_REQ_BITS;
    assign w_rem        = w_mat_bits - r_idx * c_REQ_BITS;
    assign w_bits       = (w_rem > c_REQ_BITS) ? c_REQ_BITS : w_rem;
    assign w_req_base   = w_mat_base + r_idx * c_REQ_BYTES;
    assign w_xfer_state = (r_state == c_READ_C) || (r_state == c_LOAD_A) ||
                          (r_state == c_LOAD_B) || (r_state == c_WRITE_BACK);
    assign w_fin        = bus.rsp_finish && r_outst;
    assign w_last       = (r_idx + 32'd1 == w_nreq);
    assign w_tmr_done   = (r_cnt <= 32'd1);
    assign w_start_ok   = start && (cfg_type[3:2] != 2'b11);
    assign w_changing   = (w_state_nxt != r_state);

    // Select the matrix (size, base, sel code) served by the current state.
    always_comb begin
        w_mat_bits = c_CD_BITS;
        w_mat_base = r_base[31:0];
        w_sel      = 3'b000;
        case (r_state)
            c_READ_C: begin
                w_mat_base = r_base[63:32];
                w_sel      = 3'b001;
            end
            c_LOAD_A: begin
                w_mat_bits = 32'd16384 >> w_shift;
                w_mat_base = r_base[127:96];
                w_sel      = 3'b100;
            end
            c_LOAD_B: begin
                w_mat_bits = (32'd4096 << r_type[3:2]) >> r_type[1:0];
                w_mat_base = r_base[95:64];
                w_sel      = 3'b010;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:       if (w_start_ok) w_state_nxt = c_READ_C;
            c_READ_C:     if (w_fin && w_last) w_state_nxt = c_LOAD_A;
            c_LOAD_A:     if (w_fin && w_last) w_state_nxt = c_LOAD_B;
            c_LOAD_B:     if (w_fin && w_last) w_state_nxt = c_SYSTOLIC;
            c_SYSTOLIC:   if (w_tmr_done) w_state_nxt = r_type[1] ? c_ACCUMULATE : c_WAIT_WRITE;
            c_ACCUMULATE: if (w_tmr_done) w_state_nxt = c_WAIT_WRITE;
            c_WAIT_WRITE: if (w_tmr_done) w_state_nxt = c_WRITE_BACK;
            c_WRITE_BACK: if ((r_all_fin || (w_fin && w_last)) && w_tmr_done) w_state_nxt = c_FINISH;
            c_FINISH:     w_state_nxt = c_IDLE;
            default:      w_state_nxt = c_IDLE;
        endcase
    end

    // Dwell length loaded when entering a timed state; zero times act as one.
    always_comb begin
        w_cnt_load = 32'd0;
        case (w_state_nxt)
            c_SYSTOLIC:   w_cnt_load = (r_time[95:64] == 32'd0) ? 32'd1 : r_time[95:64];
            c_ACCUMULATE: w_cnt_load = c_ACC_LOAD;
            c_WAIT_WRITE: w_cnt_load = (r_time[63:32] == 32'd0) ? 32'd1 : r_time[63:32];
            c_WRITE_BACK: w_cnt_load = (r_time[31:0] == 32'd0) ? 32'd1 : r_time[31:0];
            default:      w_cnt_load = 32'd0;
        endcase
    end

    // Latched configuration, config error pulse and the phase down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_type    <= 4'd0;
            r_base    <= 128'd0;
            r_time    <= 96'd0;
            r_cfg_err <= 1'b0;
            r_entry   <= 1'b0;
            r_cnt     <= 32'd0;
        end else begin
            if ((r_state == c_IDLE) && w_start_ok) begin
                r_type <= cfg_type;
                r_base <= cfg_base;
                r_time <= cfg_time;
            end
            r_cfg_err <= (r_state == c_IDLE) && start && (cfg_type[3:2] == 2'b11);
            r_entry   <= w_changing;
            if (w_changing) begin
                r_cnt <= w_cnt_load;
            end else if (r_cnt != 32'd0) begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end

    // Request issue: one outstanding burst, the next follows its rsp_finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= 32'd0;
            r_valid   <= 1'b0;
            r_outst   <= 1'b0;
            r_all_fin <= 1'b0;
        end else if (w_changing) begin
            r_idx     <= 32'd0;
            r_valid   <= 1'b0;
            r_outst   <= 1'b0;
            r_all_fin <= 1'b0;
        end else if (r_valid && bus.req_ready) begin
            r_valid <= 1'b0;
            r_outst <= 1'b1;
        end else if (w_fin) begin
            r_outst <= 1'b0;
            if (w_last) begin
                r_all_fin <= 1'b1;
            end else begin
                r_idx   <= r_idx + 32'd1;
                r_valid <= 1'b1;
            end
        end else if (r_entry && w_xfer_state) begin
            r_valid <= 1'b1;
        end
    end

    // Status, systolic-array controls and the request payload.
    always_comb begin
        state              = r_state;
        busy               = (r_state != c_IDLE);
        done               = (r_state == c_FINISH);
        sa_busy            = (r_state == c_SYSTOLIC);
        sa_start           = (r_state == c_SYSTOLIC) && r_entry;
        acc_en             = (r_state == c_ACCUMULATE);
        cfg_err            = r_cfg_err;
        bus.req_valid      = r_valid;
        bus.req_base       = r_valid ? w_req_base : 32'd0;
        bus.req_sel        = r_valid ? w_sel : 3'b000;
        bus.req_issend     = r_valid && (r_state == c_WRITE_BACK);
        bus.req_bits       = r_valid ? w_bits : 32'd0;
        bus.req_burst_num  = r_valid ? 5'((w_bits >> 8) - 32'd1) : 5'd0;
        bus.req_burst_size = r_valid ? 8'd32 : 8'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_tc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc_seq_ctrl
// Description : Self-checking bench for tc_seq_ctrl: directed tiles followed
//               by randomized tiles, compared against a matrix-size model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_seq_ctrl;

    typedef struct packed {
        logic [31:0] base;
        logic [2:0]  sel;
        logic        issend;
        logic [31:0] bits;
        logic [4:0]  bn;
        logic [7:0]  size;
    } req_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   cfg_type;
    logic [127:0] cfg_base;
    logic [95:0]  cfg_time;
    logic         sa_start, sa_busy, acc_en, busy, done, cfg_err;
    logic [3:0]   state;

    tc_seq_ctrl_if bus();

    tc_seq_ctrl #(.MAX_BEATS(16), .ACC_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_type(cfg_type),
        .cfg_base(cfg_base), .cfg_time(cfg_time), .bus(bus.master),
        .sa_start(sa_start), .sa_busy(sa_busy), .acc_en(acc_en),
        .state(state), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus controls (written by the main sequence only)
    int tile_id    = 0;
    int ready_mode = 0;
    int lat_mode   = 0;
    int stall_req  = 0;
    bit spur_en    = 1'b0;
    bit inj_fin    = 1'b0;

    // monitor results (written by the bus model only)
    req_t        got_q[$];
    req_t        exp_q[$];
    int          n_sys, n_sas, n_acc, n_ww, n_wb, n_done, k_last, d_fins;
    logic [63:0] trace;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] outs_vec();
        return 96'({state, busy, done, sa_start, sa_busy, acc_en, cfg_err, bus.req_valid,
                    bus.req_base, bus.req_sel, bus.req_issend, bus.req_bits,
                    bus.req_burst_num, bus.req_burst_size});
    endfunction

    // AXI-side responder and monitor: samples on negedge, then drives inputs.
    initial begin : p_bfm
        bit          outst;
        int          fin_cnt;
        int          stall_cnt;
        int          seen_id;
        bit          rdy;
        bit          held_v;
        logic [95:0] held;
        logic [3:0]  last_st;
        req_t        cur;
        outst = 1'b0; fin_cnt = 0; stall_cnt = 0; seen_id = 0; held_v = 1'b0;
        held = '0; last_st = 4'd0;
        bus.req_ready = 1'b0;
        bus.rsp_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (tile_id != seen_id) begin
                seen_id = tile_id;
                got_q.delete();
                n_sys = 0; n_sas = 0; n_acc = 0; n_ww = 0; n_wb = 0; n_done = 0;
                k_last = 0; d_fins = 0; trace = '0; last_st = 4'd0;
                stall_cnt = stall_req;
            end
            if (rst) begin
                outst = 1'b0; held_v = 1'b0;
                bus.req_ready = 1'b0;
                bus.rsp_finish = inj_fin;
                continue;
            end
            if (state != last_st) begin
                trace = {trace[59:0], state};
                last_st = state;
            end
            if (sa_busy) n_sys++;
            if (sa_start) n_sas++;
            if (acc_en) n_acc++;
            if (state == 4'd6) n_ww++;
            if (state == 4'd7) n_wb++;
            if (done) n_done++;
            cur.base = bus.req_base; cur.sel = bus.req_sel; cur.issend = bus.req_issend;
            cur.bits = bus.req_bits; cur.bn = bus.req_burst_num; cur.size = bus.req_burst_size;
            if (held_v) check("hold_stable", 96'({bus.req_valid, state, cur}), held);
            held_v = 1'b0;
            bus.rsp_finish = 1'b0;
            if (outst) begin
                fin_cnt--;
                if (fin_cnt == 0) begin
                    bus.rsp_finish = 1'b1;
                    outst = 1'b0;
                    if (state == 4'd7) begin
                        d_fins++;
                        if (d_fins == 2) k_last = n_wb;
                    end
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                bus.rsp_finish = 1'b1;
            end
            if (inj_fin) bus.rsp_finish = 1'b1;
            if (stall_cnt > 0 && bus.req_valid) begin
                rdy = 1'b0;
                stall_cnt--;
            end else if (ready_mode == 0) begin
                rdy = 1'b1;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
            end
            if (bus.req_valid && rdy) begin
                got_q.push_back(cur);
                outst = 1'b1;
                fin_cnt = (lat_mode == 0) ? 4 : int'($urandom_range(1, 6));
            end else if (bus.req_valid) begin
                held_v = 1'b1;
                held = 96'({1'b1, state, cur});
            end
            bus.req_ready = rdy;
        end
    end

    // Split a T-bit matrix into 4096-bit requests.
    task automatic add_mat(input int t, input logic [31:0] base, input logic [2:0] sel, input logic iss);
        for (int i = 0; i * 4096 < t; i++) begin
            req_t r;
            int   b;
            b        = (t - i * 4096 > 4096) ? 4096 : t - i * 4096;
            r.base   = base + 32'(i * 512);
            r.sel    = sel;
            r.issend = iss;
            r.bits   = 32'(b);
            r.bn     = 5'(b / 256 - 1);
            r.size   = 8'd32;
            exp_q.push_back(r);
        end
    endtask

    task automatic build_exp(input int s, input int d, input logic [127:0] b);
        int mm[3] = '{32, 16, 8};
        int nn[3] = '{8, 16, 32};
        int ww[4] = '{32, 16, 8, 4};
        exp_q.delete();
        add_mat(mm[s] * nn[s] * 32, b[63:32], 3'b001, 1'b0);
        add_mat(mm[s] * 16 * ww[d], b[127:96], 3'b100, 1'b0);
        add_mat(16 * nn[s] * ww[d], b[95:64], 3'b010, 1'b0);
        add_mat(mm[s] * nn[s] * 32, b[31:0], 3'b000, 1'b1);
    endtask

    task automatic wait_state(input logic [3:0] st, input string tag);
        int g;
        g = 0;
        while (state != st && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check(tag, 96'(g < 2000), 96'(1));
    endtask

    task automatic run_tile(input int s, input int d, input logic [127:0] b,
                            input logic [95:0] t, input bit poke);
        int          guard;
        int          sys_n, ww_n, wb_n;
        int          seq[$];
        logic [63:0] exp_tr;
        tile_id++;
        build_exp(s, d, b);
        repeat (2) @(negedge clk);
        cfg_type = {2'(s), 2'(d)};
        cfg_base = b;
        cfg_time = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_type = 4'($urandom);
        cfg_base = {$urandom, $urandom, $urandom, $urandom};
        cfg_time = {$urandom, $urandom, $urandom};
        if (poke) begin
            wait_state(4'd4, "poke_reach_sys");
            start = 1'b1;
            cfg_type = 4'b0100;
            @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (!(n_done > 0 && state == 4'd0) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("tile_timeout", 96'(guard < 4000), 96'(1));
        @(negedge clk);
        sys_n = (t[95:64] == 0) ? 1 : int'(t[95:64]);
        ww_n  = (t[63:32] == 0) ? 1 : int'(t[63:32]);
        wb_n  = (t[31:0] == 0) ? 1 : int'(t[31:0]);
        if (k_last > wb_n) wb_n = k_last;
        check("req_count", 96'(got_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("req%0d", i), 96'(got_q[i]), 96'(exp_q[i]));
        check("sa_busy_cycles", 96'(n_sys), 96'(sys_n));
        check("sa_start_pulses", 96'(n_sas), 96'(1));
        check("acc_cycles", 96'(n_acc), 96'((d >= 2) ? 2 : 0));
        check("wait_cycles", 96'(n_ww), 96'(ww_n));
        check("wb_cycles", 96'(n_wb), 96'(wb_n));
        check("done_pulses", 96'(n_done), 96'(1));
        seq.push_back(1); seq.push_back(2); seq.push_back(3); seq.push_back(4);
        if (d >= 2) seq.push_back(5);
        seq.push_back(6); seq.push_back(7); seq.push_back(8); seq.push_back(0);
        exp_tr = '0;
        foreach (seq[i]) exp_tr = {exp_tr[59:0], 4'(seq[i])};
        check("state_trace", 96'(trace), 96'(exp_tr));
        check("idle_after", outs_vec(), 96'(0));
    endtask

    initial begin : p_main
        int cnt;
        rst = 1'b1; start = 1'b0; cfg_type = '0; cfg_base = '0; cfg_time = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs_vec(), 96'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", outs_vec(), 96'(0));

        run_tile(1, 1, {32'h0, 32'h200, 32'h400, 32'h800}, {32'd20, 32'd3, 32'd4}, 1'b0);
        run_tile(2, 3, {32'h1000, 32'h2000, 32'h3000, 32'h4000}, {32'd5, 32'd2, 32'd1}, 1'b0);
        run_tile(0, 0, {32'h0, 32'h10000, 32'h20000, 32'h30000}, {32'd3, 32'd0, 32'd0}, 1'b0);

        stall_req = 5; spur_en = 1'b1; ready_mode = 1; lat_mode = 1;
        run_tile(1, 2, {32'h4000, 32'h5000, 32'h6000, 32'h7000}, {32'd2, 32'd1, 32'd9}, 1'b0);
        stall_req = 0;

        // invalid shape: one cfg_err pulse, sequencer stays idle
        @(negedge clk);
        cfg_type = 4'b1101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            check("bad_shape_idle", 96'(state), 96'(0));
            if (cfg_err) cnt++;
            @(negedge clk);
        end
        check("cfg_err_pulses", 96'(cnt), 96'(1));
        run_tile(0, 1, {32'h100, 32'h300, 32'h500, 32'h700}, {32'd6, 32'd2, 32'd2}, 1'b1);

        // reset during SYSTOLIC, then a stray finish, then a full tile
        tile_id++;
        @(negedge clk);
        cfg_type = 4'b0100; cfg_base = {32'h0, 32'h200, 32'h400, 32'h800};
        cfg_time = {32'd30, 32'd1, 32'd1}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(4'd4, "rst_reach_sys");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_sys", outs_vec(), 96'(0));
        rst = 1'b0;
        inj_fin = 1'b1;
        repeat (2) @(negedge clk);
        inj_fin = 1'b0;
        repeat (2) @(negedge clk);
        check("fin_after_rst", outs_vec(), 96'(0));
        run_tile(1, 0, {32'h8000, 32'h9000, 32'hA000, 32'hB000}, {32'd4, 32'd2, 32'd3}, 1'b0);

        for (int k = 0; k < 10; k++) begin
            run_tile(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     {$urandom, $urandom, $urandom, $urandom},
                     {32'($urandom_range(0, 12)), 32'($urandom_range(0, 6)), 32'($urandom_range(0, 14))},
                     (k % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
